// File: rtl/stream_fork_reg.sv
// stream_fork_reg: one-entry registered 1-to-N_OUT stream fork.
// Each accepted beat carries a destination mask. It is held in a single
// register until every selected output has taken its copy. Outputs may
// accept in different cycles. The input valid never feeds the output valids
// combinationally. The output readies do feed a_ready, which allows
// back-to-back beats.
module stream_fork_reg #(
    parameter int DATA_BW = 8,
    parameter int N_OUT   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_BW-1:0] a_data,
    input  logic [N_OUT-1:0]   a_mask,
    input  logic               a_valid,
    output logic               a_ready,
    output logic [DATA_BW-1:0] m_data,
    output logic [N_OUT-1:0]   m_valid,
    input  logic [N_OUT-1:0]   m_ready,
    output logic               busy
);

    // Holding register: occupancy flag, payload, and outputs still owed the beat.
    logic               full_q;
    logic [DATA_BW-1:0] data_q;
    logic [N_OUT-1:0]   pend_q;

    logic [N_OUT-1:0]   m_fire;
    logic               a_fire;
    logic               done;

    // Outputs are forced idle while reset is high, even before the reset edge
    // has cleared the held beat.
    assign m_data  = data_q;
    assign m_valid = rst ? '0 : ({N_OUT{full_q}} & pend_q);
    assign busy    = ~rst & full_q;

    assign m_fire  = m_valid & m_ready;

    // done: every copy still owed is handed over in this cycle, so the slot
    // frees up and a new beat can load in the same cycle without a bubble.
    assign done    = full_q & ((pend_q & ~m_fire) == '0);
    assign a_ready = ~rst & (~full_q | done);
    assign a_fire  = a_valid & a_ready;

    // Holding-register update: load, drop, retire, or clear delivered bits.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            pend_q <= '0;
            data_q <= '0;
        end else if (a_fire && (a_mask != '0)) begin
            data_q <= a_data;
            pend_q <= a_mask;
            full_q <= 1'b1;
        end else if (a_fire) begin
            // A beat with an empty mask is consumed and discarded. data_q
            // keeps the last delivered payload.
            full_q <= 1'b0;
            pend_q <= '0;
        end else if (done) begin
            full_q <= 1'b0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_q & ~m_fire;
        end
    end

endmodule

// File: doc/stream_fork_reg.md
Name: stream_fork_reg

Overview:
Parametrised successor to the team's combinational 1-to-2 stream fork. Broadcasts one input stream to N_OUT output streams through a one-entry holding register. A per-transaction destination mask selects which outputs receive each beat. Each output may accept its copy in a different cycle; the entry retires only when every selected output has taken it. Sits between a producer and several independent consumers in the streaming datapath, and breaks the valid path from input to outputs.

Parameters:
DATA_BW, 8, payload width in bits (>=1)
N_OUT, 3, number of output streams (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
a_data  input  DATA_BW  input payload
a_mask  input  N_OUT  destination mask; bit i set = deliver to output i; qualified by a_valid
a_valid  input  1  input valid
a_ready  output  1  input ready
m_data  output  DATA_BW  payload broadcast to all outputs (common bus)
m_valid  output  N_OUT  per-output valid
m_ready  input  N_OUT  per-output ready
busy  output  1  holding register occupied

Behaviour:
- State: full_q (1b), data_q (DATA_BW), pend_q (N_OUT; outputs still owed the current beat).
- Reset (rst high at clock edge): full_q=0, pend_q=0, data_q=0. While rst is high: a_ready=0, m_valid=0, busy=0. Reset mid-transaction discards the held beat; no output sees it after reset.
- m_data = data_q. m_valid[i] = full_q & pend_q[i]. busy = full_q.
- m_fire[i] = m_valid[i] & m_ready[i]. a_fire = a_valid & a_ready.
- done = full_q & ((pend_q & ~m_fire) == 0): the last owed copies are delivered this cycle.
- a_ready = ~rst & (~full_q | done). Combinational path from m_ready to a_ready is required for full throughput.
- Next state, in priority order:
  - If a_fire and a_mask != 0: data_q<=a_data, pend_q<=a_mask, full_q<=1.
  - If a_fire and a_mask == 0: beat is dropped. full_q<=0, pend_q<=0, data_q unchanged. It consumes its input cycle but produces no output.
  - Else if done: full_q<=0, pend_q<=0.
  - Else: pend_q <= pend_q & ~m_fire. full_q and data_q hold.
- Latency: an accepted beat is visible on m_valid the cycle after a_fire.
- Throughput: 1 beat/cycle when all selected outputs assert ready on the cycle the beat is presented.
- Output rules:
  - Each output receives each selected beat exactly once and in order.
  - Once m_valid[i] rises, it stays high and m_data stays stable until m_fire[i].
  - m_valid[i] never asserts for unselected outputs.
- Simultaneous events:
  - If different outputs fire in different cycles, their pend bits clear individually.
  - If the last pending output fires in the same cycle as a new a_fire, the new beat loads with no bubble.
- a_ready does not depend on a_valid. Input-side protocol: a_data/a_mask must be held while a_valid is high and a_ready is low. A violation is a producer error and is not checked.

Test Plan:
- Reset, then a_valid=1, a_data=0x5A, a_mask=3'b111, m_ready=3'b111 held -> m_valid=111, m_data=0x5A the next cycle; back-to-back beats 0x01..0x08 stream at 1 beat/cycle, each output sees 0x01..0x08 in order.
- Beat 0xA5, mask 111; m_ready[0] high at cycle 1, m_ready[1] at cycle 3, m_ready[2] at cycle 5 -> m_valid goes 111, 110, 110, 100, 100, 000. a_ready=0 through cycle 4 and 1 in cycle 5 (done). The next beat loads at cycle 5 with no bubble.
- a_mask=3'b010, data 0x33, all m_ready=1 -> only m_valid[1] pulses for one cycle; m_valid[0] and m_valid[2] stay 0 throughout.
- a_mask=3'b000, data 0x77 -> a_ready=1 and the beat is accepted; no m_valid asserts; busy stays 0; data_q keeps its previous value.
- Beat 0x11, mask 111, m_ready=000 for 10 cycles -> m_valid=111, m_data=0x11 stable, a_ready=0 throughout. Assert rst for 1 cycle -> m_valid=000, busy=0, a_ready=0 during rst and 1 after. The old beat never reappears.
- Random: N_OUT=5, DATA_BW=16, random a_valid, a_mask and m_ready over 10k cycles -> scoreboard per output matches the expected in-order filtered sequence. Assert m_data is stable while m_valid[i]&~m_ready[i].
